pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Central stall/flush scheduler for the 5-stage pipeline (IF/ID/EX/MEM/WB).
//  Detects load-use hazards in ID, applies EX branch/jump redirects, and
//  sequences halt: drain the pipeline, then freeze it.
//  Drives the PC enable, IF/ID enable and flush, ID/EX flush, and the
//  redirect mux. Counts retired instructions.
// PARAMETERS
//  PC_W        12  PC width (bits)
//  WARMUP_CYC  5   cycles after reset during which hazard/redirect detection is masked
//  DRAIN_CYC   3   cycles spent in DRAIN before HALTED (EX, MEM, WB)
// PORTS
//  clk           in   1      rising-edge clock
//  rstn          in   1      synchronous, ACTIVE-HIGH reset (1 = reset)
//  id_rs1        in   5      rs1 of instruction in ID
//  id_rs2        in   5      rs2 of instruction in ID
//  id_use_rs1    in   1      ID instruction reads rs1
//  id_use_rs2    in   1      ID instruction reads rs2
//  id_halt       in   1      ID holds a halt instruction
//  ex_rd         in   5      destination register of instruction in EX
//  ex_memread    in   1      EX instruction is a load
//  ex_redirect   in   1      EX resolved a taken branch/jump (mispredict)
//  ex_target     in   PC_W   redirect target PC
//  wb_valid      in   1      a valid instruction retires this cycle
//  pc_en         out  1      PC register update enable
//  pc_sel        out  1      1 = next PC is pc_target
//  pc_target     out  PC_W   next PC when pc_sel = 1
//  if_id_en      out  1      IF/ID register enable
//  if_id_flush   out  1      clear IF/ID to a bubble
//  id_ex_flush   out  1      clear ID/EX to a bubble
//  halted        out  1      pipeline frozen after halt
//  num_inst      out  32     retired instruction count
// BEHAVIOUR
//  - FSM states: WARM, RUN, DRAIN, HALTED. Reset -> WARM.
//    Registered on reset: warm_cnt=0, drain_cnt=0, num_inst=0, halted=0.
//  - Control outputs are combinational from the state and this cycle's inputs
//    (zero latency). Default: pc_en=1, if_id_en=1, all flushes=0, pc_sel=0.
//  - WARM: defaults only; all hazard inputs ignored. warm_cnt increments each cycle.
//    When warm_cnt==WARMUP_CYC-1: -> RUN.
//  - RUN, priority high to low:
//    1 ex_redirect: pc_sel=1, pc_target=ex_target, if_id_flush=1, id_ex_flush=1.
//      Suppresses load-use and id_halt in the same cycle.
//    2 load-use: ex_memread && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) ||
//      (id_use_rs2 && id_rs2==ex_rd)). Then pc_en=0, if_id_en=0, id_ex_flush=1.
//      Exactly one bubble per hazard.
//    3 id_halt (no load-use): pc_en=0, if_id_flush=1; halt moves to EX; -> DRAIN,
//      drain_cnt=0.
//  - DRAIN: pc_en=0, if_id_en=0, id_ex_flush=1. drain_cnt increments each cycle.
//    When drain_cnt==DRAIN_CYC-1: -> HALTED.
//    ex_redirect in DRAIN (the halt was on a wrong path): apply redirect as in RUN,
//    -> RUN, drain_cnt cleared.
//  - HALTED: halted=1; pc_en=0, if_id_en=0, if_id_flush=1, id_ex_flush=1.
//    Only reset leaves HALTED.
//  - num_inst: +1 on each wb_valid when state!=HALTED; saturates at 32'hFFFF_FFFF.
//    wb_valid during WARM is counted.
//  - Reset asserted mid-operation (any state) -> WARM next edge; all counters cleared.
//    Reset wins over every other input.
// CONFIGURATION
//  PIPE_HAZARD_PERF_EN defined: adds outputs stall_cnt[31:0] and flush_cnt[31:0].
//    stall_cnt += 1 per load-use bubble cycle; flush_cnt += 1 per applied redirect.
//    Both saturate and clear on reset.
//  PIPE_HAZARD_PERF_EN undefined: these ports and registers do not exist;
//    all other behaviour is identical.
// TESTING
//  1 Reset held 2 cycles, then ex_redirect=1 at cycles 1..4 -> pc_sel=0 while in WARM;
//    state is RUN at cycle 5.
//  2 RUN, ex_memread=1, ex_rd=5, id_use_rs2=1, id_rs2=5 for 1 cycle ->
//    pc_en=0, if_id_en=0, id_ex_flush=1 for exactly that cycle.
//  3 Same as 2 but ex_rd=0 -> no stall (defaults).
//  4 RUN, ex_redirect=1 with the load-use condition true, ex_target=12'h0A4 ->
//    pc_sel=1, pc_target=12'h0A4, both flushes=1, pc_en=1.
//  5 id_halt=1 in RUN -> DRAIN 3 cycles -> halted=1 on 4th cycle edge; wb_valid
//    afterwards does not change num_inst.
//  6 id_halt, then ex_redirect in 2nd DRAIN cycle -> back to RUN, halted stays 0;
//    with PIPE_HAZARD_PERF_EN, flush_cnt=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Central stall/flush scheduler for the 5-stage IF/ID/EX/MEM/WB pipeline.
// It detects load-use hazards in ID, applies EX branch/jump redirects, and
// sequences a halt: the pipeline is first drained and then frozen. It also
// counts retired instructions.
//
// The control outputs are combinational from the current state and this
// cycle's inputs, so they take effect with zero latency.
//
// Ports
//   clk          rising-edge clock
//   rstn         synchronous reset, ACTIVE HIGH (1 = reset). The name is
//                historical; the polarity really is active high.
//   id_rs1/2     source registers of the instruction in ID
//   id_use_rs1/2 the ID instruction actually reads that source
//   id_halt      ID holds a halt instruction
//   ex_rd        destination register of the instruction in EX
//   ex_memread   the EX instruction is a load
//   ex_redirect  EX resolved a taken branch/jump (mispredict)
//   ex_target    redirect target PC
//   wb_valid     a valid instruction retires this cycle
//   pc_en        PC register update enable
//   pc_sel       1 = next PC is pc_target
//   pc_target    next PC when pc_sel = 1 (zero otherwise)
//   if_id_en     IF/ID register enable
//   if_id_flush  clear IF/ID to a bubble
//   id_ex_flush  clear ID/EX to a bubble
//   halted       pipeline frozen after halt
//   num_inst     retired instruction count (saturating)
//
// Build option
//   PIPE_HAZARD_PERF_EN : when defined, adds stall_cnt (load-use bubble cycles)
//                         and flush_cnt (applied redirects). Both counters
//                         saturate and clear on reset.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int PC_W       = 12,
    parameter int WARMUP_CYC = 5,
    parameter int DRAIN_CYC  = 3
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic            id_halt,
    input  logic [4:0]      ex_rd,
    input  logic            ex_memread,
    input  logic            ex_redirect,
    input  logic [PC_W-1:0] ex_target,
    input  logic            wb_valid,
    output logic            pc_en,
    output logic            pc_sel,
    output logic [PC_W-1:0] pc_target,
    output logic            if_id_en,
    output logic            if_id_flush,
    output logic            id_ex_flush,
    output logic            halted,
    output logic [31:0]     num_inst
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt
`endif
);

    localparam int WARM_W  = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
    localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [WARM_W-1:0]  WARM_LAST  = WARM_W'(WARMUP_CYC - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {
        ST_WARM,
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t              state_reg, state_next;
    logic [WARM_W-1:0]   warm_cnt_reg, warm_cnt_next;
    logic [DRAIN_W-1:0]  drain_cnt_reg, drain_cnt_next;
    logic                halted_reg;
    logic [31:0]         num_inst_reg;

    // Events that actually took effect this cycle (after state masking and
    // priority). The performance counters count these, not the raw inputs.
    logic                redirect_taken;
    logic                stall_taken;

    // ------------------------------------------------------------------
    // Load-use detection: one comparator per ID source operand.
    // Register x0 never creates a hazard because it is hard-wired to zero.
    // ------------------------------------------------------------------
    logic [4:0] id_src [2];
    logic [1:0] id_src_use;
    logic [1:0] src_hit;
    logic       load_use;

    assign id_src[0]  = id_rs1;
    assign id_src[1]  = id_rs2;
    assign id_src_use = {id_use_rs2, id_use_rs1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
            assign src_hit[gi] = id_src_use[gi] && (id_src[gi] == ex_rd);
        end
    endgenerate

    assign load_use = ex_memread && (ex_rd != 5'd0) && (|src_hit);

    // ------------------------------------------------------------------
    // Next-state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        warm_cnt_next  = warm_cnt_reg;
        drain_cnt_next = drain_cnt_reg;
        redirect_taken = 1'b0;
        stall_taken    = 1'b0;
        pc_en          = 1'b1;
        pc_sel         = 1'b0;
        pc_target      = '0;
        if_id_en       = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;

        case (state_reg)
            ST_WARM: begin
                // Pipeline contents are not trustworthy yet: ignore hazards.
                warm_cnt_next = warm_cnt_reg + WARM_W'(1);
                if (warm_cnt_reg == WARM_LAST) begin
                    state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                if (ex_redirect) begin
                    // The ID instruction is on the wrong path, so neither its
                    // load-use hazard nor its halt matters.
                    redirect_taken = 1'b1;
                end else if (load_use) begin
                    // Hold IF and ID, inject one bubble into EX. Next cycle
                    // the load has moved to MEM and the hazard is gone.
                    stall_taken = 1'b1;
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end else if (id_halt) begin
                    // Halt proceeds to EX; nothing behind it is fetched.
                    pc_en          = 1'b0;
                    if_id_flush    = 1'b1;
                    state_next     = ST_DRAIN;
                    drain_cnt_next = '0;
                end
            end

            ST_DRAIN: begin
                if (ex_redirect) begin
                    // An older branch mispredicted: the halt was speculative.
                    redirect_taken = 1'b1;
                    state_next     = ST_RUN;
                    drain_cnt_next = '0;
                end else begin
                    pc_en          = 1'b0;
                    if_id_en       = 1'b0;
                    id_ex_flush    = 1'b1;
                    drain_cnt_next = drain_cnt_reg + DRAIN_W'(1);
                    if (drain_cnt_reg == DRAIN_LAST) begin
                        state_next = ST_HALTED;
                    end
                end
            end

            ST_HALTED: begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end

            default: begin
                state_next = ST_WARM;
            end
        endcase

        if (redirect_taken) begin
            pc_sel      = 1'b1;
            pc_target   = ex_target;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_reg     <= ST_WARM;
            warm_cnt_reg  <= '0;
            drain_cnt_reg <= '0;
            halted_reg    <= 1'b0;
            num_inst_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            warm_cnt_reg  <= warm_cnt_next;
            drain_cnt_reg <= drain_cnt_next;
            halted_reg    <= (state_next == ST_HALTED);
            if (wb_valid && (state_reg != ST_HALTED) && (num_inst_reg != 32'hFFFF_FFFF)) begin
                num_inst_reg <= num_inst_reg + 32'd1;
            end
        end
    end

    assign halted   = halted_reg;
    assign num_inst = num_inst_reg;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] flush_cnt_reg;

    always_ff @(posedge clk) begin
        if (rstn) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (stall_taken && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            if (redirect_taken && (flush_cnt_reg != 32'hFFFF_FFFF)) begin
                flush_cnt_reg <= flush_cnt_reg + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`else
    // Without the performance counters the taken-event flags only steer the
    // control outputs above.
`endif

endmodule
